// File: rtl/usb_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_ring_pkg
// Brief    : Shared constants and types for the capture-ring reader.
// Revision : 1.0 - initial release
// ============================================================================
package usb_ring_pkg;

    localparam int RING_ADDR_W   = 14;
    localparam int HDR_BYTES     = 2;
    localparam int MAX_FRAME_LEN = (2 ** RING_ADDR_W) - 2;
    localparam int RING_PTR_W    = RING_ADDR_W + 1;

    typedef logic [RING_PTR_W-1:0] ring_ptr_t;

    typedef enum logic [1:0] {
        HDR_LO  = 2'd0,
        HDR_HI  = 2'd1,
        PAYLOAD = 2'd2,
        HALT    = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_ring_reader_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ring_rd_skid_fifo
// Brief    : Two-entry FIFO catching BRAM read returns ahead of the parser.
// Revision : 1.0 - initial release
// ============================================================================
module ring_rd_skid_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clr) begin
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_push_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (i_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_idx];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/usb_ring_reader.sv
`default_nettype none
// ============================================================================
// Module   : usb_ring_reader
// Brief    : Walks the capture ring behind the writer and streams frame payloads.
// Revision : 1.0 - initial release
// ============================================================================
module usb_ring_reader
    import usb_ring_pkg::*;
#(
    parameter int ADDR_WIDTH = RING_ADDR_W,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    input  logic [DATA_WIDTH-1:0] bram_dout_b,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  frame_err
);

    localparam logic [ADDR_WIDTH:0]     c_ptr_one = (ADDR_WIDTH + 1)'(1);
    localparam logic [2*DATA_WIDTH-1:0] c_len_one = (2 * DATA_WIDTH)'(1);
    localparam logic [31:0]             c_max_len = 32'((2 ** ADDR_WIDTH) - 2);

    rd_state_t               r_state;
    logic [ADDR_WIDTH:0]     r_issue_ptr;
    logic [ADDR_WIDTH:0]     r_rd_ptr;
    logic                    r_in_flight;
    logic                    r_frame_err;
    logic [DATA_WIDTH-1:0]   r_len_lo;
    logic [2*DATA_WIDTH-1:0] r_remaining;

    logic [DATA_WIDTH-1:0]   w_head;
    logic [1:0]              w_count;
    logic                    w_nonempty;
    logic                    w_pop;
    logic                    w_issue;
    logic [2:0]              w_occupancy;
    logic [2*DATA_WIDTH-1:0] w_len;

    ring_rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (flush),
        .i_push      (r_in_flight),
        .i_push_data (bram_dout_b),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_nonempty = (w_count != 2'd0);

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            HDR_LO, HDR_HI: w_pop = w_nonempty;
            PAYLOAD:        w_pop = w_nonempty && m_ready;
            default:        w_pop = 1'b0;
        endcase
    end

    // Reads already landed or still returning both count against the two FIFO slots.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
    assign w_issue     = (r_issue_ptr != wr_ptr) && (r_state != HALT) && (w_occupancy < 3'd2);
    assign w_len       = {w_head, r_len_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HDR_LO;
            r_issue_ptr <= '0;
            r_rd_ptr    <= '0;
            r_in_flight <= 1'b0;
            r_frame_err <= 1'b0;
            r_len_lo    <= '0;
            r_remaining <= '0;
        end else if (flush) begin
            r_state     <= HDR_LO;
            r_issue_ptr <= wr_ptr;
            r_rd_ptr    <= wr_ptr;
            r_in_flight <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_in_flight <= w_issue;
            if (w_issue) begin
                r_issue_ptr <= r_issue_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case (r_state)
                HDR_LO: begin
                    if (w_nonempty) begin
                        r_len_lo <= w_head;
                        r_state  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_nonempty) begin
                        if (w_len == '0) begin
                            r_state <= HDR_LO;
                        end else if (32'(w_len) > c_max_len) begin
                            r_state     <= HALT;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_state     <= PAYLOAD;
                            r_remaining <= w_len;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pop) begin
                        r_remaining <= r_remaining - c_len_one;
                        if (r_remaining == c_len_one) begin
                            r_state <= HDR_LO;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bram_addr_b = r_issue_ptr[ADDR_WIDTH-1:0];
    assign rd_ptr      = r_rd_ptr;
    assign frame_err   = r_frame_err;
    assign m_valid     = (r_state == PAYLOAD) && w_nonempty;
    assign m_data      = w_head;
    assign m_last      = m_valid && (r_remaining == c_len_one);

endmodule
`default_nettype wire

// File: tb/tb_usb_ring_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_ring_reader
// Brief    : Self-checking bench: ring/BRAM model, frame-level payload model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_ring_reader;

    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;
    typedef logic [7:0] bq_t[$];

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [AW:0]   wr_ptr  = '0;
    logic          flush   = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] bram_addr_b;
    logic [7:0]    bram_dout_b;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_last;
    logic          frame_err;

    logic [7:0]    mem [0:DEPTH-1];
    logic [AW:0]   wfill = '0;
    int            rmode = 0;
    int            cyc   = 0;
    int            n_tests = 0;
    int            n_fail  = 0;
    beat_t         exp_q[$];
    beat_t         log_q[$];
    int            log_cyc[$];

    usb_ring_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ptr      (wr_ptr),
        .flush       (flush),
        .rd_ptr      (rd_ptr),
        .bram_addr_b (bram_addr_b),
        .bram_dout_b (bram_dout_b),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .frame_err   (frame_err)
    );

    initial forever #5 clk = ~clk;

    // Dual-port BRAM read port with one cycle of registered latency.
    always @(posedge clk) bram_dout_b <= mem[bram_addr_b];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: a frame is a little-endian length then that many payload bytes.
    task automatic put_byte(input logic [7:0] b);
        mem[wfill[AW-1:0]] = b;
        wfill = wfill + 1'b1;
    endtask

    task automatic put_frame(input bq_t pay);
        int len;
        len = pay.size();
        put_byte(len[7:0]);
        put_byte(len[15:8]);
        foreach (pay[i]) begin
            put_byte(pay[i]);
            exp_q.push_back('{data: pay[i], last: (i == len - 1)});
        end
    endtask

    task automatic check_log(input string name, input bq_t expd);
        check({name, "_count"}, log_q.size(), expd.size());
        foreach (expd[i]) begin
            if (i < log_q.size()) begin
                check($sformatf("%s_data%0d", name, i), log_q[i].data, expd[i]);
                check($sformatf("%s_last%0d", name, i), log_q[i].last, (i == expd.size() - 1));
            end
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rd_ptr == wr_ptr && exp_q.size() == 0 && !m_valid) break;
        end
        check({name, "_drained_in_time"}, (i < 4000), 1);
        tick();
    endtask

    task automatic monitor();
        bit    stalled = 1'b0;
        beat_t held;
        logic [AW-1:0] outstanding;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || flush) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h last %0b, model has nothing pending", m_data, m_last);
                    end else begin
                        check("beat", {m_data, m_last}, {exp_q[0].data, exp_q[0].last});
                        if (stalled) check("stall_hold", {m_data, m_last}, {held.data, held.last});
                        if (m_ready) begin
                            log_q.push_back('{data: m_data, last: m_last});
                            log_cyc.push_back(cyc);
                            void'(exp_q.pop_front());
                            stalled = 1'b0;
                        end else begin
                            stalled = 1'b1;
                            held    = '{data: m_data, last: m_last};
                        end
                    end
                end else if (stalled) begin
                    check("valid_held_while_stalled", m_valid, 1);
                    stalled = 1'b0;
                end
                outstanding = bram_addr_b - rd_ptr[AW-1:0];
                check("outstanding_reads_le2", (outstanding <= 2), 1);
                if (frame_err) check("halt_no_valid", m_valid, 0);
            end
        end
    endtask

    task automatic ready_driver();
        int pcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin
                    m_ready = (pcnt % 3 == 0);
                    pcnt++;
                end
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b1;
            endcase
        end
    endtask

    initial begin
        bq_t         p;
        int          lat;
        int          len;
        logic [AW:0] start;
        logic [AW:0] want;
        logic [AW:0] gap;
        int          step;

        fork
            monitor();
            ready_driver();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_ptr", rd_ptr, 0);
        check("reset_bram_addr", bram_addr_b, 0);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_last", m_last, 0);
        check("reset_m_data", m_data, 0);
        check("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single frame at address 0 with latency and back-to-back timing.
        log_q.delete();
        log_cyc.delete();
        p = '{8'hAA, 8'hBB, 8'hCC};
        put_frame(p);
        wr_ptr = wfill;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) begin
                lat = n;
                break;
            end
        end
        check("first_valid_latency", lat, 4);
        drain("single");
        check_log("single", p);
        if (log_cyc.size() == 3) check("single_consecutive", log_cyc[2] - log_cyc[0], 2);
        check("single_rd_ptr", rd_ptr, 5);

        // Backpressure with a 1,0,0 ready pattern.
        log_q.delete();
        rmode = 1;
        put_frame(p);
        wr_ptr = wfill;
        drain("backpressure");
        rmode = 0;
        check_log("backpressure", p);
        check("backpressure_rd_ptr", rd_ptr, 10);

        // Frame straddling the top of the ring.
        wfill  = (AW + 1)'(DEPTH - 3);
        wr_ptr = wfill;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        check("wrap_flush_rd_ptr", rd_ptr, DEPTH - 3);
        log_q.delete();
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        put_frame(p);
        wr_ptr = wfill;
        drain("wrap");
        check_log("wrap", p);
        check("wrap_rd_ptr", rd_ptr, 32'h4003);

        // Empty frame followed by a one-byte frame.
        start = rd_ptr;
        log_q.delete();
        p.delete();
        put_frame(p);
        p = '{8'h5A};
        put_frame(p);
        wr_ptr = wfill;
        drain("zero_len");
        check_log("zero_len", p);
        want = start + (AW + 1)'(5);
        check("zero_len_rd_ptr", rd_ptr, want);

        // Oversized length halts the reader until flush.
        start = wfill;
        log_q.delete();
        put_byte(8'hFF);
        put_byte(8'hFF);
        wr_ptr = wfill;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (frame_err) break;
        end
        check("bad_len_frame_err", frame_err, 1);
        repeat (5) tick();
        want = start + (AW + 1)'(2);
        check("bad_len_rd_ptr", rd_ptr, want);
        check("bad_len_no_beats", log_q.size(), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_clears_frame_err", frame_err, 0);
        check("flush_rd_ptr_eq_wr_ptr", rd_ptr, wr_ptr);
        p = '{8'hC3, 8'h3C};
        put_frame(p);
        wr_ptr = wfill;
        drain("after_halt");
        check_log("after_halt", p);

        // Flush in the middle of a 10-byte payload.
        log_q.delete();
        p.delete();
        for (int i = 0; i < 10; i++) p.push_back(8'(8'h40 + i * 3));
        put_frame(p);
        wr_ptr = wfill;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (log_q.size() >= 3) break;
        end
        check("accepted_before_flush", log_q.size(), 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid_low", m_valid, 0);
        check("flush_mid_rd_ptr", rd_ptr, wr_ptr);
        repeat (10) @(negedge clk);
        check("flush_no_stale", log_q.size(), 3);
        tick();

        // Random frames, random commit chunks, random ready.
        rmode = 2;
        for (int f = 0; f < 30; f++) begin
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 250) : $urandom_range(0, 12);
            p.delete();
            for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
            put_frame(p);
        end
        while (wr_ptr != wfill) begin
            gap  = wfill - wr_ptr;
            step = $urandom_range(1, 8);
            if (step > int'(gap)) step = int'(gap);
            wr_ptr = wr_ptr + (AW + 1)'(step);
            repeat ($urandom_range(0, 3)) tick();
            tick();
        end
        drain("random");
        check("random_rd_ptr", rd_ptr, wfill);
        rmode = 0;

        // Asynchronous reset in the middle of a frame.
        p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        put_frame(p);
        wr_ptr = wfill;
        repeat (6) tick();
        #2;
        rst    = 1'b1;
        wr_ptr = '0;
        wfill  = '0;
        #1;
        check("async_rst_rd_ptr", rd_ptr, 0);
        check("async_rst_m_valid", m_valid, 0);
        check("async_rst_bram_addr", bram_addr_b, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
